// File: rtl/mult_accum_if.sv
// Start/valid handshake bundle for the shift-and-add multiply-accumulate unit.
interface mult_accum_if #(
    parameter int A_W = 8,
    parameter int B_W = 7
);
    logic               start;
    logic [A_W-1:0]     multiplicandin;
    logic [B_W-1:0]     multiplierin;
    logic [B_W-1:0]     addendin;
    logic [A_W+B_W-1:0] product;
    logic               valid;
    logic               busy;

    modport master (
        output start, multiplicandin, multiplierin, addendin,
        input  product, valid, busy
    );

    modport slave (
        input  start, multiplicandin, multiplierin, addendin,
        output product, valid, busy
    );
endinterface

// File: rtl/mult_accum.sv
// Sequential multiply-accumulate: product = multiplicand * multiplier + addend, one multiplier bit per cycle.
// Optional MULT_ACCUM_EARLY_TERM_EN ends RUN once the remaining multiplier bits are all zero.
module mult_accum #(
    parameter int A_W = 8,
    parameter int B_W = 7
) (
    input  logic         clk,
    input  logic         reset,
    mult_accum_if.slave  bus
);
    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [P_W-1:0]     mcand_q, mcand_d;
    logic [B_W-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    acc_d    = P_W'(bus.addendin);
                    mcand_d  = P_W'(bus.multiplicandin);
                    mplier_d = bus.multiplierin;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Operands are frozen here; a start pulse during RUN has no effect.
                if (mplier_q[0])
                    acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == CNT_W'(B_W - 1))
                    state_d = DONE;
`ifdef MULT_ACCUM_EARLY_TERM_EN
                if (mplier_d == '0)
                    state_d = DONE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.product = acc_q;
    assign bus.valid   = (state_q == DONE);
    assign bus.busy    = (state_q == RUN);
endmodule
